// File: rtl/gate_mon_pkg.sv
// Shared types and defaults for the AND-cell toggle/functional monitor.
// Contents: measurement FSM state enum, default counter and window widths.
// Imported by gate_toggle_monitor and its saturating counter.
package gate_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    COUNT  = 2'd2,
    REPORT = 2'd3
  } state_e;

  localparam int CNT_W_DEF = 16;
  localparam int WIN_W_DEF = 16;

endpackage

// File: rtl/gate_toggle_monitor_sat_counter.sv
// Saturating up-counter used for the rise, fall and error tallies.
// Ports: CLK/RST (async active-high), clr (sync clear, wins over inc), inc, cnt.
// Latency: cnt reflects clr/inc one edge later; holds at all-ones, never wraps.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/gate_toggle_monitor.sv
// Samples a 4-input AND cell (IN1..IN4 -> Q) over a programmable window, counting
// Q rising/falling edges and functional mismatches; result returned via RES_VALID/RES_READY.
// Ports: CLK, RST, START, WINDOW, IN1..IN4, Q in; BUSY, RES_VALID, RISE/FALL/ERR_CNT out (all registered).
module gate_toggle_monitor
  import gate_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIN_W-1:0] WINDOW,
  input  logic             IN1,
  input  logic             IN2,
  input  logic             IN3,
  input  logic             IN4,
  input  logic             Q,
  output logic             BUSY,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [CNT_W-1:0] RISE_CNT,
  output logic [CNT_W-1:0] FALL_CNT,
  output logic [CNT_W-1:0] ERR_CNT
);

  state_e           state_q;
  logic [WIN_W-1:0] win_q;
  logic             q_prev_q;
  logic             busy_q;
  logic             res_valid_q;

  logic [4:0] smp;
  logic       smp_known;
  logic       and_ref;
  logic       in_cnt;
  logic       accept;
  logic       rise_inc;
  logic       fall_inc;
  logic       err_inc;

  assign smp     = {Q, IN4, IN3, IN2, IN1};
  assign and_ref = IN1 & IN2 & IN3 & IN4;
  assign in_cnt  = (state_q == COUNT);
  assign accept  = (state_q == IDLE) && START && (WINDOW != '0);

  // Any X/Z on the sampled bits makes the XOR reduction X. Only meaningful in
  // 4-state simulation; real hardware sees 0/1 and this folds to constant 1.
  assign smp_known = !((^smp) === 1'bx);

  // An unknown sample is always an error and never an edge.
  assign rise_inc = in_cnt && smp_known && !q_prev_q && Q;
  assign fall_inc = in_cnt && smp_known && q_prev_q && !Q;
  assign err_inc  = in_cnt && (!smp_known || (Q != and_ref));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      win_q       <= '0;
      q_prev_q    <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            win_q   <= WINDOW;
            busy_q  <= 1'b1;
            state_q <= ARM;
          end
        end
        ARM: begin
          // Reference level for the first COUNT sample; no counting here.
          q_prev_q <= Q;
          state_q  <= COUNT;
        end
        COUNT: begin
          if (smp_known) begin
            q_prev_q <= Q;
          end
          win_q <= win_q - WIN_W'(1);
          if (win_q == WIN_W'(1)) begin
            res_valid_q <= 1'b1;
            state_q     <= REPORT;
          end
        end
        REPORT: begin
          if (RES_READY) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_rise (
    .CLK (CLK),
    .RST (RST),
    .clr (accept),
    .inc (rise_inc),
    .cnt (RISE_CNT)
  );

  sat_counter #(.W(CNT_W)) u_fall (
    .CLK (CLK),
    .RST (RST),
    .clr (accept),
    .inc (fall_inc),
    .cnt (FALL_CNT)
  );

  sat_counter #(.W(CNT_W)) u_err (
    .CLK (CLK),
    .RST (RST),
    .clr (accept),
    .inc (err_inc),
    .cnt (ERR_CNT)
  );

  assign BUSY      = busy_q;
  assign RES_VALID = res_valid_q;

endmodule
